// File: rtl/svm_feature_streamer.sv
// svm_feature_streamer: gathers a serial stream of signed feature beats into a
// packed frame for the SVM classifier, tags frames alternately valence/arousal,
// flags framing errors, and holds the classifier result for a downstream consumer.
module svm_feature_streamer #(
  parameter int unsigned NBITS       = 5,
  parameter int unsigned F_WIDTH     = 214,
  parameter int unsigned LOG_F_WIDTH = $clog2(F_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  // serial feature stream
  input  logic signed [NBITS-1:0]    s_feature,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  // packed frame to classifier
  output logic [NBITS*F_WIDTH-1:0]   fout_features,
  output logic                       fout_valid,
  input  logic                       fout_ready,
  output logic                       fout_is_arousal,
  output logic                       frame_error,
  // classifier result capture
  input  logic                       svm_dout_valid,
  input  logic                       svm_valence,
  input  logic                       svm_arousal,
  output logic                       result_valid,
  output logic                       result_valence,
  output logic                       result_arousal,
  input  logic                       result_ready,
  output logic                       result_overrun
);

  localparam logic [LOG_F_WIDTH-1:0] LAST_IDX = LOG_F_WIDTH'(F_WIDTH - 1);
  localparam logic [LOG_F_WIDTH-1:0] IDX_ONE  = LOG_F_WIDTH'(1);

  typedef enum logic {FILL, SEND} state_t;

  state_t                 state;
  logic [LOG_F_WIDTH-1:0] fidx;

  logic beat_acc;
  logic frame_fire;
  logic at_last_idx;

  // Handshake qualifiers; s_ready/fout_valid are registers so neither input
  // loops combinationally back to its own handshake output.
  always_comb begin
    beat_acc    = s_valid && s_ready;
    frame_fire  = fout_valid && fout_ready;
    at_last_idx = (fidx == LAST_IDX);
  end

  // Frame assembly FSM: FILL collects beats, SEND holds the frame until it fires.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= FILL;
      fidx            <= '0;
      s_ready         <= 1'b0;
      fout_valid      <= 1'b0;
      fout_is_arousal <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        FILL: begin
          s_ready    <= 1'b1;
          fout_valid <= 1'b0;
          if (beat_acc) begin
            if (s_last && at_last_idx) begin
              // Final beat in the right slot: frame complete.
              fout_features[int'(fidx)*NBITS +: NBITS] <= s_feature;
              fidx       <= '0;
              state      <= SEND;
              s_ready    <= 1'b0;
              fout_valid <= 1'b1;
            end else if (s_last || at_last_idx) begin
              // Early or missing last marker: drop the frame and resync.
              fidx        <= '0;
              frame_error <= 1'b1;
            end else begin
              fout_features[int'(fidx)*NBITS +: NBITS] <= s_feature;
              fidx <= fidx + IDX_ONE;
            end
          end
        end
        SEND: begin
          s_ready    <= 1'b0;
          fout_valid <= 1'b1;
          if (frame_fire) begin
            state           <= FILL;
            s_ready         <= 1'b1;
            fout_valid      <= 1'b0;
            fout_is_arousal <= ~fout_is_arousal;
          end
        end
        default: begin
          state      <= FILL;
          fidx       <= '0;
          s_ready    <= 1'b0;
          fout_valid <= 1'b0;
        end
      endcase
    end
  end

  // Result holding register with sticky overrun when an unconsumed result is replaced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_valid   <= 1'b0;
      result_valence <= 1'b0;
      result_arousal <= 1'b0;
      result_overrun <= 1'b0;
    end else if (svm_dout_valid) begin
      result_valid   <= 1'b1;
      result_valence <= svm_valence;
      result_arousal <= svm_arousal;
      if (result_valid && !result_ready) begin
        result_overrun <= 1'b1;
      end
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svm_feature_streamer.sv
// Directed self-checking bench for svm_feature_streamer with NBITS=5, F_WIDTH=4.
module tb_svm_feature_streamer;

  localparam int unsigned NBITS   = 5;
  localparam int unsigned F_WIDTH = 4;
  localparam int unsigned FW      = NBITS * F_WIDTH;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic signed [NBITS-1:0] s_feature = '0;
  logic                    s_valid = 1'b0;
  logic                    s_last = 1'b0;
  logic                    s_ready;
  logic [FW-1:0]           fout_features;
  logic                    fout_valid;
  logic                    fout_ready = 1'b1;
  logic                    fout_is_arousal;
  logic                    frame_error;
  logic                    svm_dout_valid = 1'b0;
  logic                    svm_valence = 1'b0;
  logic                    svm_arousal = 1'b0;
  logic                    result_valid;
  logic                    result_valence;
  logic                    result_arousal;
  logic                    result_ready = 1'b0;
  logic                    result_overrun;

  int total = 0;
  int bad   = 0;

  svm_feature_streamer #(
    .NBITS  (NBITS),
    .F_WIDTH(F_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_feature      (s_feature),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .fout_features  (fout_features),
    .fout_valid     (fout_valid),
    .fout_ready     (fout_ready),
    .fout_is_arousal(fout_is_arousal),
    .frame_error    (frame_error),
    .svm_dout_valid (svm_dout_valid),
    .svm_valence    (svm_valence),
    .svm_arousal    (svm_arousal),
    .result_valid   (result_valid),
    .result_valence (result_valence),
    .result_arousal (result_arousal),
    .result_ready   (result_ready),
    .result_overrun (result_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [NBITS-1:0] f, input logic l);
    int n = 0;
    s_feature = f;
    s_last    = l;
    s_valid   = 1'b1;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL beat_accept_timeout: s_ready=%b required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [NBITS-1:0] f0, input logic [NBITS-1:0] f1,
                            input logic [NBITS-1:0] f2, input logic [NBITS-1:0] f3);
    send_beat(f0, 1'b0);
    send_beat(f1, 1'b0);
    send_beat(f2, 1'b0);
    send_beat(f3, 1'b1);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    tick();
    total++;
    if ({s_ready, fout_valid, fout_is_arousal, frame_error, result_valid,
         result_valence, result_arousal, result_overrun} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b fv=%b tag=%b ferr=%b rv=%b val=%b aro=%b ovr=%b required all 0",
               s_ready, fout_valid, fout_is_arousal, frame_error, result_valid,
               result_valence, result_arousal, result_overrun);
    end
    rst = 1'b1;
    tick();
    total++;
    if (s_ready !== 1'b1 || fout_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_fill: s_ready=%b fout_valid=%b required 1 0", s_ready, fout_valid);
    end
  endtask

  task automatic test_basic_frame();
    fout_ready = 1'b1;
    send_frame(5'h1F, 5'h02, 5'h10, 5'h0F);
    total++;
    if (fout_valid !== 1'b1 || fout_features !== {5'h0F, 5'h10, 5'h02, 5'h1F} ||
        fout_is_arousal !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL frame1: fv=%b data=%h tag=%b rdy=%b required 1 %h 0 0",
               fout_valid, fout_features, fout_is_arousal, s_ready, {5'h0F, 5'h10, 5'h02, 5'h1F});
    end
    tick();
    total++;
    if (fout_valid !== 1'b0 || fout_is_arousal !== 1'b1) begin
      bad++;
      $display("FAIL frame1_fire: fv=%b tag=%b required 0 1", fout_valid, fout_is_arousal);
    end
    send_frame(5'h01, 5'h02, 5'h03, 5'h04);
    total++;
    if (fout_valid !== 1'b1 || fout_features !== {5'h04, 5'h03, 5'h02, 5'h01} ||
        fout_is_arousal !== 1'b1) begin
      bad++;
      $display("FAIL frame2: fv=%b data=%h tag=%b required 1 %h 1",
               fout_valid, fout_features, fout_is_arousal, {5'h04, 5'h03, 5'h02, 5'h01});
    end
    tick();
    total++;
    if (fout_valid !== 1'b0 || fout_is_arousal !== 1'b0) begin
      bad++;
      $display("FAIL frame2_fire: fv=%b tag=%b required 0 0", fout_valid, fout_is_arousal);
    end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    fout_ready = 1'b0;
    send_frame(5'h0A, 5'h15, 5'h00, 5'h1F);
    // Keep pushing a beat while stalled; it must not be taken.
    s_feature = 5'h11;
    s_valid   = 1'b1;
    s_last    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (fout_valid !== 1'b1 || s_ready !== 1'b0 || fout_is_arousal !== 1'b0 ||
          fout_features !== {5'h1F, 5'h00, 5'h15, 5'h0A}) begin
        errs++;
      end
      tick();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_hold: %0d of 10 stall cycles unstable, last fv=%b rdy=%b data=%h required 1 0 %h",
               errs, fout_valid, s_ready, fout_features, {5'h1F, 5'h00, 5'h15, 5'h0A});
    end
    s_valid    = 1'b0;
    s_last     = 1'b0;
    fout_ready = 1'b1;
    tick();
    total++;
    if (fout_valid !== 1'b0 || fout_is_arousal !== 1'b1 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: fv=%b tag=%b ferr=%b required 0 1 0",
               fout_valid, fout_is_arousal, frame_error);
    end
  endtask

  task automatic test_short_frame();
    send_beat(5'h03, 1'b0);
    send_beat(5'h04, 1'b1);
    total++;
    if (frame_error !== 1'b1 || fout_valid !== 1'b0) begin
      bad++;
      $display("FAIL short_err: ferr=%b fv=%b required 1 0", frame_error, fout_valid);
    end
    tick();
    total++;
    if (frame_error !== 1'b0) begin
      bad++;
      $display("FAIL short_err_pulse: ferr=%b required 0", frame_error);
    end
    send_frame(5'h05, 5'h06, 5'h07, 5'h08);
    total++;
    if (fout_valid !== 1'b1 || fout_is_arousal !== 1'b1 ||
        fout_features !== {5'h08, 5'h07, 5'h06, 5'h05}) begin
      bad++;
      $display("FAIL short_recover: fv=%b tag=%b data=%h required 1 1 %h",
               fout_valid, fout_is_arousal, fout_features, {5'h08, 5'h07, 5'h06, 5'h05});
    end
    tick();
  endtask

  task automatic test_long_frame();
    send_beat(5'h09, 1'b0);
    send_beat(5'h0A, 1'b0);
    send_beat(5'h0B, 1'b0);
    send_beat(5'h0C, 1'b0);
    total++;
    if (frame_error !== 1'b1 || fout_valid !== 1'b0 || fout_is_arousal !== 1'b0) begin
      bad++;
      $display("FAIL long_err: ferr=%b fv=%b tag=%b required 1 0 0",
               frame_error, fout_valid, fout_is_arousal);
    end
    send_frame(5'h1E, 5'h1D, 5'h1C, 5'h1B);
    total++;
    if (fout_valid !== 1'b1 || fout_is_arousal !== 1'b0 || frame_error !== 1'b0 ||
        fout_features !== {5'h1B, 5'h1C, 5'h1D, 5'h1E}) begin
      bad++;
      $display("FAIL long_recover: fv=%b tag=%b ferr=%b data=%h required 1 0 0 %h",
               fout_valid, fout_is_arousal, frame_error, fout_features, {5'h1B, 5'h1C, 5'h1D, 5'h1E});
    end
    tick();
    total++;
    if (fout_is_arousal !== 1'b1) begin
      bad++;
      $display("FAIL long_fire_tag: tag=%b required 1", fout_is_arousal);
    end
  endtask

  task automatic test_mid_reset();
    send_beat(5'h01, 1'b0);
    send_beat(5'h01, 1'b0);
    rst = 1'b0;
    tick();
    total++;
    if ({s_ready, fout_valid, fout_is_arousal, frame_error} !== 4'h0) begin
      bad++;
      $display("FAIL midreset_outputs: rdy=%b fv=%b tag=%b ferr=%b required 0 0 0 0",
               s_ready, fout_valid, fout_is_arousal, frame_error);
    end
    rst = 1'b1;
    send_frame(5'h11, 5'h12, 5'h13, 5'h14);
    total++;
    if (fout_valid !== 1'b1 || fout_is_arousal !== 1'b0 ||
        fout_features !== {5'h14, 5'h13, 5'h12, 5'h11}) begin
      bad++;
      $display("FAIL midreset_frame: fv=%b tag=%b data=%h required 1 0 %h",
               fout_valid, fout_is_arousal, fout_features, {5'h14, 5'h13, 5'h12, 5'h11});
    end
    tick();
  endtask

  task automatic test_results();
    apply_reset();
    result_ready   = 1'b0;
    svm_dout_valid = 1'b1;
    svm_valence    = 1'b1;
    svm_arousal    = 1'b0;
    tick();
    total++;
    if ({result_valid, result_valence, result_arousal, result_overrun} !== 4'b1100) begin
      bad++;
      $display("FAIL result_first: v/val/aro/ovr=%b%b%b%b required 1100",
               result_valid, result_valence, result_arousal, result_overrun);
    end
    svm_valence = 1'b0;
    svm_arousal = 1'b1;
    tick();
    svm_dout_valid = 1'b0;
    tick();
    total++;
    if ({result_valid, result_valence, result_arousal, result_overrun} !== 4'b1011) begin
      bad++;
      $display("FAIL result_overrun: v/val/aro/ovr=%b%b%b%b required 1011",
               result_valid, result_valence, result_arousal, result_overrun);
    end
    apply_reset();
    svm_dout_valid = 1'b1;
    svm_valence    = 1'b1;
    svm_arousal    = 1'b1;
    tick();
    result_ready = 1'b1;
    svm_valence  = 1'b0;
    svm_arousal  = 1'b1;
    tick();
    total++;
    if ({result_valid, result_valence, result_arousal, result_overrun} !== 4'b1010) begin
      bad++;
      $display("FAIL result_swap: v/val/aro/ovr=%b%b%b%b required 1010",
               result_valid, result_valence, result_arousal, result_overrun);
    end
    svm_dout_valid = 1'b0;
    tick();
    total++;
    if (result_valid !== 1'b0 || result_overrun !== 1'b0) begin
      bad++;
      $display("FAIL result_clear: valid=%b ovr=%b required 0 0", result_valid, result_overrun);
    end
    result_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_mid_reset();
    test_results();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
